// File: rtl/input_quant_loader_pkg.sv
// Shared encodings and default geometry for the input quantizer/loader and
// the generated layer-0 neuron modules that slice its output vector.
package input_quant_loader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_FILL  = 2'd0;
  localparam state_t ST_XFER  = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  localparam int NUM_FEATURES_DEF = 49;
  localparam int IN_BITS_DEF      = 2;
  localparam int FEAT_W_DEF       = 16;

endpackage

// File: rtl/input_quant_loader_quantizer.sv
// Combinational feature quantizer: arithmetic shift, signed bias, then clamp
// into an unsigned IN_BITS code.
module feat_quantizer
  import input_quant_loader_pkg::*;
#(
  parameter int FEAT_W  = FEAT_W_DEF,
  parameter int IN_BITS = IN_BITS_DEF,
  parameter int SHIFT   = 12,
  parameter int OFFSET  = 2
) (
  input  logic [FEAT_W-1:0]  s_data,
  output logic [IN_BITS-1:0] code
);

  localparam logic signed [FEAT_W:0] OFS  = (FEAT_W+1)'(OFFSET);
  localparam logic signed [FEAT_W:0] MAXC = (FEAT_W+1)'((2**IN_BITS) - 1);

  logic signed [FEAT_W:0] ext;
  logic signed [FEAT_W:0] t;

  // One extra bit keeps the bias addition from overflowing at the extremes.
  always_comb begin
    ext = $signed({s_data[FEAT_W-1], s_data});
    t   = (ext >>> SHIFT) + OFS;
    if (t[FEAT_W])
      code = '0;
    else if (t > MAXC)
      code = '1;
    else
      code = t[IN_BITS-1:0];
  end

endmodule

// File: rtl/input_quant_loader.sv
// Collects one quantized code per beat into an assembly buffer and hands the
// completed vector to the layer-0 array through a single output register.
//
// state    | meaning
// ST_FILL  | accepting features into the assembly buffer
// ST_XFER  | sample complete, waiting for the output register to free up
// ST_DRAIN | over-long sample, discarding beats up to s_last
module input_quant_loader
  import input_quant_loader_pkg::*;
#(
  parameter int NUM_FEATURES = NUM_FEATURES_DEF,
  parameter int FEAT_W       = FEAT_W_DEF,
  parameter int IN_BITS      = IN_BITS_DEF,
  parameter int SHIFT        = 12,
  parameter int OFFSET       = 2,
  parameter int CNT_W        = 6
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [FEAT_W-1:0]               s_data,
  input  logic                            s_last,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [NUM_FEATURES*IN_BITS-1:0] m_data,
  output logic                            err_len,
  output logic [15:0]                     sample_cnt
);

  state_t                          state, state_nxt;
  logic [CNT_W-1:0]                counter;
  logic [NUM_FEATURES*IN_BITS-1:0] asm_buf;
  logic [IN_BITS-1:0]              code;
  logic                            beat, at_end, load;

  feat_quantizer #(
    .FEAT_W (FEAT_W),
    .IN_BITS(IN_BITS),
    .SHIFT  (SHIFT),
    .OFFSET (OFFSET)
  ) u_quant (
    .s_data(s_data),
    .code  (code)
  );

  assign beat   = s_valid && s_ready;
  assign at_end = (counter == CNT_W'(NUM_FEATURES - 1));
  // Output register is free when empty or being drained this very cycle.
  assign load   = (state == ST_XFER) && (!m_valid || m_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL: begin
        if (beat && at_end)
          state_nxt = s_last ? ST_XFER : ST_DRAIN;
      end
      ST_XFER:  if (load) state_nxt = ST_FILL;
      ST_DRAIN: if (beat && s_last) state_nxt = ST_FILL;
      default:  state_nxt = ST_FILL;
    endcase
  end

  always_comb begin
    s_ready = (state != ST_XFER);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      counter    <= '0;
      asm_buf    <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      err_len    <= 1'b0;
      sample_cnt <= '0;
    end else begin
      if (beat && state == ST_FILL) begin
        for (int i = 0; i < NUM_FEATURES; i++)
          if (counter == CNT_W'(i)) asm_buf[i*IN_BITS +: IN_BITS] <= code;
        if (s_last && !at_end) begin
          counter <= '0;
          err_len <= 1'b1;
        end else begin
          counter <= counter + 1'b1;
          if (!s_last) err_len <= err_len | at_end;
        end
      end
      if (beat && state == ST_DRAIN && s_last)
        counter <= '0;
      if (load) begin
        m_data     <= asm_buf;
        m_valid    <= 1'b1;
        sample_cnt <= sample_cnt + 16'd1;
        counter    <= '0;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_input_quant_loader.sv
// Scoreboard bench for input_quant_loader: expected vectors are queued when a
// well-formed sample is sent and compared when the DUT hands them off.
module tb_input_quant_loader;

  localparam int NF = 49;
  localparam int VW = NF * 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid, s_ready, s_last;
  logic [15:0]   s_data;
  logic          m_valid, m_ready;
  logic [VW-1:0] m_data;
  logic          err_len;
  logic [15:0]   sample_cnt;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [VW-1:0] exp_q[$];
  logic [15:0]   feat[64];
  int            exp_cnt = 0;

  input_quant_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .err_len   (err_len),
    .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] quant(input logic [15:0] d);
    int v, t;
    v = int'($signed(d));
    t = (v >>> 12) + 2;
    if (t < 0) return 2'd0;
    if (t > 3) return 2'd3;
    return 2'(t);
  endfunction

  // Handshake happens at the next rising edge; inputs are stable from here.
  always @(negedge clk) begin
    if (rst_n && m_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_m_valid", 128'(m_valid), 128'(0));
      end else if (m_ready) begin
        check("m_data", 128'(m_data), 128'(exp_q[0]));
        void'(exp_q.pop_front());
      end else begin
        check("m_data_hold", 128'(m_data), 128'(exp_q[0]));
      end
    end
  end

  task automatic send_beat(input logic [15:0] d, input logic last);
    logic ok;
    int   budget;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    budget  = 0;
    ok      = 1'b0;
    while (!ok && budget < 200) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    if (!ok) check("s_ready_timeout", 128'(0), 128'(1));
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_sample(input int n, input bit well_formed);
    logic [VW-1:0] e;
    for (int i = 0; i < n; i++) send_beat(feat[i], (i == n - 1));
    if (well_formed) begin
      for (int i = 0; i < NF; i++) e[i*2 +: 2] = quant(feat[i]);
      exp_q.push_back(e);
      exp_cnt++;
    end
  endtask

  task automatic fill_const(input logic [15:0] d);
    for (int i = 0; i < 64; i++) feat[i] = d;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) feat[i] = 16'($urandom_range(0, 65535));
  endtask

  task automatic wait_drain(input string tag);
    int budget = 0;
    while (exp_q.size() != 0 && budget < 500) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check(tag, 128'(exp_q.size()), 128'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] sweep_exp;
    sweep_exp = 12'b00_00_01_11_11_10;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready",    128'(s_ready),    128'(1));
    check("rst_m_valid",    128'(m_valid),    128'(0));
    check("rst_m_data",     128'(m_data),     128'(0));
    check("rst_err_len",    128'(err_len),    128'(0));
    check("rst_sample_cnt", 128'(sample_cnt), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Quantizer sweep with one-cycle latency to m_valid.
    fill_const(16'h0000);
    feat[0] = 16'h0000; feat[1] = 16'h1000; feat[2] = 16'h7FFF;
    feat[3] = 16'hF000; feat[4] = 16'hE000; feat[5] = 16'h8000;
    send_sample(NF, 1'b1);
    @(posedge clk);
    #1;
    check("sweep_latency", 128'(m_valid), 128'(1));
    check("sweep_lsbs",    128'(m_data[11:0]), 128'(sweep_exp));
    wait_drain("sweep_drain");

    // All-ones sample.
    fill_const(16'h1000);
    send_sample(NF, 1'b1);
    @(posedge clk);
    #1;
    check("basic_latency", 128'(m_valid), 128'(1));
    check("basic_ones",    128'(m_data),  128'({VW{1'b1}}));
    wait_drain("basic_drain");
    check("basic_cnt", 128'(sample_cnt), 128'(exp_cnt));
    check("basic_err", 128'(err_len),    128'(0));

    // Backpressure: two samples queued, then released back-to-back.
    m_ready = 1'b0;
    fill_rand();
    send_sample(NF, 1'b1);
    fill_rand();
    send_sample(NF, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("bp_s_ready_stall", 128'(s_ready), 128'(0));
    check("bp_m_valid_held",  128'(m_valid), 128'(1));
    m_ready = 1'b1;
    wait_drain("bp_drain");
    check("bp_cnt", 128'(sample_cnt), 128'(exp_cnt));

    // Short sample: s_last on beat 10.
    fill_rand();
    send_sample(10, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("short_err",     128'(err_len), 128'(1));
    check("short_no_out",  128'(m_valid), 128'(0));
    fill_rand();
    send_sample(NF, 1'b1);
    wait_drain("short_recover");
    check("short_cnt", 128'(sample_cnt), 128'(exp_cnt));

    // Long sample: 52 beats; err_len is already sticky, so check the drain.
    fill_rand();
    send_sample(52, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("long_err",    128'(err_len), 128'(1));
    check("long_no_out", 128'(m_valid), 128'(0));
    check("long_cnt",    128'(sample_cnt), 128'(exp_cnt));
    fill_rand();
    send_sample(NF, 1'b1);
    wait_drain("long_recover");
    check("long_cnt_after", 128'(sample_cnt), 128'(exp_cnt));

    // Reset mid-sample discards the partial sample.
    fill_rand();
    for (int i = 0; i < 20; i++) send_beat(feat[i], 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cnt = 0;
    check("mid_rst_s_ready", 128'(s_ready),    128'(1));
    check("mid_rst_m_valid", 128'(m_valid),    128'(0));
    check("mid_rst_m_data",  128'(m_data),     128'(0));
    check("mid_rst_err",     128'(err_len),    128'(0));
    check("mid_rst_cnt",     128'(sample_cnt), 128'(0));
    fill_rand();
    send_sample(NF, 1'b1);
    wait_drain("mid_rst_recover");
    repeat (10) @(posedge clk);
    #1;
    check("mid_rst_one_vec", 128'(sample_cnt), 128'(1));
    check("mid_rst_idle",    128'(m_valid),    128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
